// File: rtl/approx_cmp_error_monitor.sv
// Error-rate monitor for approximate comparators: scores apx EQ/GT/LT flags against
// exact unsigned comparison and accumulates saturating mismatch counts over a window.
module approx_cmp_error_monitor #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 32,
    parameter int WINDOW = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             apx_eq,
    input  logic             apx_gt,
    input  logic             apx_lt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_eq_cnt,
    output logic [CNT_W-1:0] err_gt_cnt,
    output logic [CNT_W-1:0] err_lt_cnt,
    output logic [CNT_W-1:0] err_any_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  acc_cnt_reg;
    logic              accept;
    logic              clr;

    logic              s1_valid_reg;
    logic [WIDTH-1:0]  s1_a_reg;
    logic [WIDTH-1:0]  s1_b_reg;
    logic              s1_eq_reg, s1_gt_reg, s1_lt_reg;
    logic              mis_eq, mis_gt, mis_lt;

    logic              s2_valid_reg;
    logic              s2_eq_reg, s2_gt_reg, s2_lt_reg, s2_any_reg;
    logic [4:0]        inc;
    logic [5*CNT_W-1:0] cnt_flat;

    assign accept = in_valid && in_ready;
    // Pipeline is always empty in IDLE/DONE, so clearing here never drops a sample.
    assign clr    = start && (state_reg == IDLE || state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= RUN;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        acc_cnt_reg <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt_reg <= acc_cnt_reg + 1'b1;
                        if (acc_cnt_reg == LAST_IDX) begin
                            state_reg <= DRAIN;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid_reg && !s2_valid_reg) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_eq_reg    <= 1'b0;
            s1_gt_reg    <= 1'b0;
            s1_lt_reg    <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_eq_reg    <= 1'b0;
            s2_gt_reg    <= 1'b0;
            s2_lt_reg    <= 1'b0;
            s2_any_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg  <= a;
                s1_b_reg  <= b;
                s1_eq_reg <= apx_eq;
                s1_gt_reg <= apx_gt;
                s1_lt_reg <= apx_lt;
            end
            s2_valid_reg <= s1_valid_reg;
            s2_eq_reg    <= mis_eq;
            s2_gt_reg    <= mis_gt;
            s2_lt_reg    <= mis_lt;
            s2_any_reg   <= mis_eq | mis_gt | mis_lt;
        end
    end

    assign mis_eq = s1_eq_reg != (s1_a_reg == s1_b_reg);
    assign mis_gt = s1_gt_reg != (s1_a_reg >  s1_b_reg);
    assign mis_lt = s1_lt_reg != (s1_a_reg <  s1_b_reg);

    // Counter order: sample, eq, gt, lt, any.
    assign inc = {s2_any_reg, s2_lt_reg, s2_gt_reg, s2_eq_reg, 1'b1};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (clr)
                    cnt_reg <= '0;
                else if (s2_valid_reg && inc[gi] && cnt_reg != {CNT_W{1'b1}})
                    cnt_reg <= cnt_reg + 1'b1;
            end
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign sample_cnt  = cnt_flat[0*CNT_W +: CNT_W];
    assign err_eq_cnt  = cnt_flat[1*CNT_W +: CNT_W];
    assign err_gt_cnt  = cnt_flat[2*CNT_W +: CNT_W];
    assign err_lt_cnt  = cnt_flat[3*CNT_W +: CNT_W];
    assign err_any_cnt = cnt_flat[4*CNT_W +: CNT_W];
endmodule

// File: tb/tb_approx_cmp_error_monitor.sv
// Directed bench: three monitors (WINDOW 4, 3, 1) share the sample stream, each with its own start.
module tb_approx_cmp_error_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        apx_eq = 1'b0, apx_gt = 1'b0, apx_lt = 1'b0;
    logic        start4 = 1'b0, start3 = 1'b0, start1 = 1'b0;

    logic        rdy4, busy4, done4, rdy3, busy3, done3, rdy1, busy1, done1;
    logic [31:0] smp4, eq4, gt4, lt4, any4;
    logic [31:0] smp3, eq3, gt3, lt3, any3;
    logic [31:0] smp1, eq1, gt1, lt1, any1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    approx_cmp_error_monitor #(.WIDTH(32), .CNT_W(32), .WINDOW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
        .a(a), .b(b), .apx_eq(apx_eq), .apx_gt(apx_gt), .apx_lt(apx_lt),
        .busy(busy4), .done(done4), .sample_cnt(smp4), .err_eq_cnt(eq4),
        .err_gt_cnt(gt4), .err_lt_cnt(lt4), .err_any_cnt(any4));

    approx_cmp_error_monitor #(.WIDTH(32), .CNT_W(32), .WINDOW(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .b(b), .apx_eq(apx_eq), .apx_gt(apx_gt), .apx_lt(apx_lt),
        .busy(busy3), .done(done3), .sample_cnt(smp3), .err_eq_cnt(eq3),
        .err_gt_cnt(gt3), .err_lt_cnt(lt3), .err_any_cnt(any3));

    approx_cmp_error_monitor #(.WIDTH(32), .CNT_W(32), .WINDOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .apx_eq(apx_eq), .apx_gt(apx_gt), .apx_lt(apx_lt),
        .busy(busy1), .done(done1), .sample_cnt(smp1), .err_eq_cnt(eq1),
        .err_gt_cnt(gt1), .err_lt_cnt(lt1), .err_any_cnt(any1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic e, input logic g, input logic l);
        a = av; b = bv; apx_eq = e; apx_gt = g; apx_lt = l;
    endtask

    // Presents one sample for exactly one edge.
    task automatic sample(input logic [31:0] av, input logic [31:0] bv,
                          input logic e, input logic g, input logic l);
        drive(av, bv, e, g, l);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic done_of(input int which);
        case (which)
            4: return done4;
            3: return done3;
            default: return done1;
        endcase
    endfunction

    task automatic wait_done(input int which, input string tag);
        int n = 0;
        while (!done_of(which) && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done_of(which)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle behaviour
        tick(); tick(); tick();
        rst_n = 1'b1;
        check("rst_done", {31'd0, done4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_ready", {31'd0, rdy4}, 32'd0);
        check("rst_smp", smp4, 32'd0);
        check("rst_any", any4, 32'd0);
        drive(32'd5, 32'd3, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        check("idle_smp", smp4, 32'd0);
        check("idle_any", any4, 32'd0);
        $display("step idle: smp=%0d any=%0d", smp4, any4);

        // Correct flags, WINDOW=4
        start4 = 1'b1; tick(); start4 = 1'b0;
        check("run_ready", {31'd0, rdy4}, 32'd1);
        sample(32'd5, 32'd3, 1'b0, 1'b1, 1'b0);
        sample(32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        sample(32'd7, 32'd7, 1'b1, 1'b0, 1'b0);
        sample(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_done(4, "ok_done");
        check("ok_smp", smp4, 32'd4);
        check("ok_eq", eq4, 32'd0);
        check("ok_gt", gt4, 32'd0);
        check("ok_lt", lt4, 32'd0);
        check("ok_any", any4, 32'd0);
        check("ok_busy", {31'd0, busy4}, 32'd0);
        $display("step correct: smp=%0d any=%0d", smp4, any4);

        // Equal operands, all flags low
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) sample(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        wait_done(4, "eq0_done");
        check("eq0_eq", eq4, 32'd4);
        check("eq0_gt", gt4, 32'd0);
        check("eq0_lt", lt4, 32'd0);
        check("eq0_any", any4, 32'd4);
        $display("step eqzero: eq=%0d any=%0d", eq4, any4);

        // MSB boundary, swapped gt/lt, WINDOW=3
        start3 = 1'b1; tick(); start3 = 1'b0;
        for (int i = 0; i < 3; i++) sample(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        wait_done(3, "msb_done");
        check("msb_gt", gt3, 32'd3);
        check("msb_lt", lt3, 32'd3);
        check("msb_any", any3, 32'd3);
        check("msb_eq", eq3, 32'd0);
        check("msb_smp", smp3, 32'd3);
        $display("step msb: gt=%0d lt=%0d any=%0d", gt3, lt3, any3);

        // Gaps and stray starts, WINDOW=4
        start4 = 1'b1; tick(); start4 = 1'b0;
        sample(32'd5, 32'd3, 1'b0, 1'b1, 1'b0);
        tick();
        sample(32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        start4 = 1'b1; tick(); start4 = 1'b0;
        check("gap_ready", {31'd0, rdy4}, 32'd1);
        check("gap_busy", {31'd0, busy4}, 32'd1);
        sample(32'd7, 32'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; start4 = 1'b1;
        tick();
        check("last_ready", {31'd0, rdy4}, 32'd0);
        check("last_busy", {31'd0, busy4}, 32'd1);
        check("last_done", {31'd0, done4}, 32'd0);
        tick();
        start4 = 1'b0;
        check("drain1_done", {31'd0, done4}, 32'd0);
        check("drain1_busy", {31'd0, busy4}, 32'd1);
        tick();
        check("drain2_done", {31'd0, done4}, 32'd0);
        check("drain2_smp", smp4, 32'd4);
        tick();
        check("gap_done3", {31'd0, done4}, 32'd1);
        check("gap_busy3", {31'd0, busy4}, 32'd0);
        tick(); tick();
        in_valid = 1'b0;
        check("gap_smp", smp4, 32'd4);
        check("gap_any", any4, 32'd0);
        $display("step gaps: smp=%0d done=%0d", smp4, done4);

        // WINDOW=1: eq flag wrong on the only sample
        start1 = 1'b1; tick(); start1 = 1'b0;
        sample(32'd2, 32'd1, 1'b1, 1'b1, 1'b0);
        check("w1_ready", {31'd0, rdy1}, 32'd0);
        wait_done(1, "w1_done");
        check("w1_smp", smp1, 32'd1);
        check("w1_eq", eq1, 32'd1);
        check("w1_any", any1, 32'd1);
        check("frozen3", gt3, 32'd3);
        $display("step w1: smp=%0d eq=%0d", smp1, eq1);

        // Reset mid-run
        start4 = 1'b1; tick(); start4 = 1'b0;
        sample(32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        sample(32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'd0, busy4}, 32'd0);
        check("mrst_ready", {31'd0, rdy4}, 32'd0);
        check("mrst_smp", smp4, 32'd0);
        check("mrst_lt", lt4, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) sample(32'd4, 32'd4, 1'b1, 1'b0, 1'b0);
        wait_done(4, "post_done");
        check("post_smp", smp4, 32'd4);
        check("post_any", any4, 32'd0);
        $display("step midreset: smp=%0d", smp4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
